// File: rtl/grid_port_arbiter_pkg.sv
// grid_port_arbiter_pkg
//   Shared types and constants for the placement grid port arbiter.
//   GRID_EMPTY     : cell value meaning "no instance placed here"
//   TAG_ID_W       : width of the requester ID carried with each access
//                    (NREQ is limited to 8)
//   ret_tag_t      : tag travelling alongside an access toward the read return
//   acc_e          : kind of memory command registered for the RAM
//   id_w()         : index width needed for n requesters
package grid_port_arbiter_pkg;

  localparam int GRID_EMPTY = -1;
  localparam int TAG_ID_W   = 3;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_e;

  typedef struct packed {
    logic                vld;  // a read (legal or trapped) owns this slot
    logic                oob;  // trapped read: return zero instead of RAM data
    logic [TAG_ID_W-1:0] id;   // requester that issued the read
  } ret_tag_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grid_port_arbiter_if.sv
// grid_port_arbiter_if
//   Requester-side bundle of the grid port arbiter.
//   master modport : requester side (drives req/we/addr/wdata/lock)
//   slave modport  : arbiter side (drives gnt/rvalid/rdata/oob)
//   addr and wdata are flattened; requester i sits at [i*W +: W].
interface grid_port_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic [NREQ-1:0]        oob;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata, oob
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata, oob
  );
endinterface

// File: rtl/grid_port_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. The search starts one position after
//   ptr (wrapping), so the last winner has the lowest priority.
//   Ports:
//     mask : eligible requesters
//     ptr  : index of the previous winner
//     gnt  : one-hot winner (zero when mask is empty)
//     idx  : binary index of the winner
//     any  : at least one requester eligible
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] mask,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                start;
  int                p;
  int                pos;

  assign dbl = {mask, mask};

  always_comb begin
    // Rotate so the start position lands on bit 0, take the lowest set bit,
    // then rotate the found position back into requester numbering.
    start = (int'(ptr) >= NREQ - 1) ? 0 : int'(ptr) + 1;
    rot   = NREQ'(dbl >> start);
    any   = 1'b0;
    p     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        p   = k;
      end
    end
    pos = start + p;
    if (pos >= NREQ) pos = pos - NREQ;
    idx = ID_W'(pos);
    gnt = any ? (NREQ'(1) << pos) : '0;
  end

endmodule

// File: rtl/grid_port_arbiter.sv
// grid_port_arbiter
//   Shares the single-port placement grid RAM among NREQ requesters with
//   round-robin arbitration. The winning access is registered onto mem_*,
//   read returns are routed back to their requester, and addresses at or
//   above GRID_CELLS are trapped (gnt+oob pulse, no RAM strobe, reads
//   return zero).
//   Optional feature: define ARB_LOCK_EN to let a requester hold the grant
//   across accesses (lock=1 on a grant keeps only that requester eligible
//   until its next grant with lock=0).
//   Ports:
//     clk, reset_n           clock, asynchronous active-low reset
//     rq (slave modport)     requester req/we/addr/wdata/lock, gnt/rvalid/rdata/oob
//     mem_read, mem_write    RAM strobes, valid the cycle after the grant decision
//     mem_addr, mem_wdata    RAM command; hold their last values when idle
//     mem_rdata              RAM read data, RD_LAT cycles after mem_read
module grid_port_arbiter
  import grid_port_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int GRID_CELLS = 81,
  parameter int RD_LAT     = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  grid_port_arbiter_if.slave  rq,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int ID_W = id_w(NREQ);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   oob_q, oob_d;
  acc_e              acc_q, acc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  ret_tag_t          tag_q, tag_d;
  ret_tag_t [RD_LAT-1:0] ret_q, ret_d;

  logic [NREQ-1:0]   cand;
  logic [NREQ-1:0]   pick_gnt;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_oob;
  logic              lock_hold;
  ret_tag_t          ret_out;

`ifdef ARB_LOCK_EN
  logic            lock_act_q, lock_act_d;
  logic [ID_W-1:0] lock_own_q, lock_own_d;
  assign lock_hold = lock_act_q;
`else
  logic unused_lock;
  assign unused_lock = ^rq.lock;
  assign lock_hold   = 1'b0;
`endif

  // A requester granted this cycle is still showing the request it was just
  // granted for, so it sits out one cycle.
  always_comb begin
    cand = rq.req & ~gnt_q;
`ifdef ARB_LOCK_EN
    if (lock_act_q) cand = cand & (NREQ'(1) << lock_own_q);
`endif
  end

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .mask (cand),
    .ptr  (ptr_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    sel_addr  = rq.addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    sel_wdata = rq.wdata[int'(pick_idx)*DATA_W +: DATA_W];
    sel_we    = rq.we[pick_idx];
    sel_oob   = ({1'b0, sel_addr} >= (ADDR_W+1)'(GRID_CELLS));

    ptr_d       = ptr_q;
    gnt_d       = '0;
    oob_d       = '0;
    acc_d       = ACC_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag_d       = '0;

    if (pick_any) begin
      gnt_d = pick_gnt;
      if (!lock_hold) ptr_d = pick_idx;
      if (sel_oob) begin
        oob_d = pick_gnt;
      end else begin
        acc_d       = sel_we ? ACC_WRITE : ACC_READ;
        mem_addr_d  = sel_addr;
        mem_wdata_d = sel_wdata;
      end
      // Trapped reads still get a return slot so rvalid keeps normal timing.
      tag_d.vld = !sel_we;
      tag_d.oob = sel_oob;
      tag_d.id  = TAG_ID_W'(pick_idx);
    end

    ret_d[0] = tag_q;
    for (int i = 1; i < RD_LAT; i++) ret_d[i] = ret_q[i-1];
  end

`ifdef ARB_LOCK_EN
  always_comb begin
    lock_act_d = lock_act_q;
    lock_own_d = lock_own_q;
    if (pick_any) begin
      if (rq.lock[pick_idx]) begin
        lock_act_d = 1'b1;
        lock_own_d = pick_idx;
      end else begin
        lock_act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_act_q <= 1'b0;
      lock_own_q <= '0;
    end else begin
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= ID_W'(NREQ - 1);
      gnt_q       <= '0;
      oob_q       <= '0;
      acc_q       <= ACC_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
      ret_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      oob_q       <= oob_d;
      acc_q       <= acc_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
      ret_q       <= ret_d;
    end
  end

  // Return stage: the tag has aged RD_LAT cycles past the command, lining up
  // with mem_rdata for that read.
  assign ret_out = ret_q[RD_LAT-1];

  always_comb begin
    rq.rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ret_out.vld && (ret_out.id == TAG_ID_W'(i))) rq.rvalid[i] = 1'b1;
    end
  end

  assign rq.rdata = (ret_out.vld && !ret_out.oob) ? mem_rdata : '0;
  assign rq.gnt   = gnt_q;
  assign rq.oob   = oob_q;

  assign mem_read  = (acc_q == ACC_READ);
  assign mem_write = (acc_q == ACC_WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
